// File: rtl/sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package sub_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } sub_state_t;

   localparam int DEFAULT_SUB_WIDTH = 8;

   // Counter must hold 0..width so the width itself stays representable.
   function automatic int sub_cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/sub_bit_cell.sv
// One-bit full-subtractor cell: d = a - b - bin, bout = borrow out of this bit.
module sub_bit_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell reused LSB first,
// borrow carried between cycles, start/busy/done handshake.
module serial_subtractor
   import sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_SUB_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int CNT_W = sub_cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   sub_state_t       state_reg;
   sub_state_t       state_next;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   // Only the upper WIDTH-1 result bits need storing; the final cell output
   // completes the word on the last shift.
   logic [WIDTH-1:1] d_sr;
   logic [WIDTH-1:0] d_shift;
   logic             borrow_r;
   logic [CNT_W-1:0] cnt;
   logic             cell_d;
   logic             cell_bo;
   logic             load;
   logic             last_bit;

   sub_bit_cell u_cell (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (borrow_r),
      .d    (cell_d),
      .bout (cell_bo)
   );

   assign last_bit = (cnt == LAST_CNT);
   assign d_shift  = {cell_d, d_sr};

   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (last_bit) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (start) begin
               load       = 1'b1;
               state_next = SHIFT;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         a_sr       <= '0;
         b_sr       <= '0;
         d_sr       <= '0;
         borrow_r   <= 1'b0;
         cnt        <= '0;
         diff       <= '0;
         borrow_out <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (load) begin
            a_sr     <= a;
            b_sr     <= b;
            borrow_r <= 1'b0;
            cnt      <= '0;
         end else if (state_reg == SHIFT) begin
            a_sr     <= a_sr >> 1;
            b_sr     <= b_sr >> 1;
            d_sr     <= d_shift[WIDTH-1:1];
            borrow_r <= cell_bo;
            cnt      <= cnt + CNT_W'(1);
            // Result registers update on entry to DONE and hold until the next one.
            if (last_bit) begin
               diff       <= d_shift;
               borrow_out <= cell_bo;
            end
         end
      end
   end

   assign busy = (state_reg == SHIFT);
   assign done = (state_reg == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: WIDTH=8 vectors, random and corner sequences, plus an
// exhaustive WIDTH=4 sweep against an arithmetic reference model.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start8, start4;
   logic [7:0] a8, b8, diff8;
   logic [3:0] a4, b4, diff4;
   logic       busy8, done8, borrow8;
   logic       busy4, done4, borrow4;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] exp_diff;
      logic       exp_borrow;
   } vec_t;

   vec_t vecs [5];

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start8),
      .a          (a8),
      .b          (b8),
      .busy       (busy8),
      .done       (done8),
      .diff       (diff8),
      .borrow_out (borrow8)
   );

   serial_subtractor #(.WIDTH(4)) dut4 (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start4),
      .a          (a4),
      .b          (b4),
      .busy       (busy4),
      .done       (done4),
      .diff       (diff4),
      .borrow_out (borrow4)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: modular difference and borrow from plain integer arithmetic.
   function automatic int ref_diff(input int x, input int y, input int w);
      int m;
      m = 1 << w;
      return (x - y + m) % m;
   endfunction

   task automatic op8(input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] ed, input logic eb);
      int cyc, busy_n;
      @(negedge clk);
      start8 = 1'b1; a8 = x; b8 = y;
      @(negedge clk);
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      cyc = 1; busy_n = 0;
      while (!done8 && cyc < 40) begin
         if (busy8) busy_n++;
         @(negedge clk);
         cyc++;
      end
      $display("op w8 a=%0d b=%0d -> diff=%0d borrow=%0d cycles=%0d", x, y, diff8, borrow8, cyc);
      check("latency8", cyc, 9);
      check("busy_cycles8", busy_n, 8);
      check("diff8", diff8, ed);
      check("borrow8", borrow8, eb);
      check("busy_in_done8", busy8, 0);
      @(negedge clk);
      check("done_pulse_len8", done8, 0);
   endtask

   task automatic op4(input logic [3:0] x, input logic [3:0] y);
      int cyc;
      logic [3:0] ed;
      ed = 4'(ref_diff(x, y, 4));
      @(negedge clk);
      start4 = 1'b1; a4 = x; b4 = y;
      @(negedge clk);
      start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
      cyc = 1;
      while (!done4 && cyc < 30) begin
         @(negedge clk);
         cyc++;
      end
      $display("op w4 a=%0d b=%0d -> diff=%0d borrow=%0d cycles=%0d", x, y, diff4, borrow4, cyc);
      check("latency4", cyc, 5);
      check("diff4", diff4, ed);
      check("borrow4", borrow4, (x < y) ? 1 : 0);
   endtask

   initial begin
      int n, dc;
      int dcyc [4];
      logic [7:0] dd [4];
      logic db [4];
      logic [7:0] rx, ry;

      vecs[0] = '{a: 8'd200, b: 8'd55,  exp_diff: 8'd145, exp_borrow: 1'b0};
      vecs[1] = '{a: 8'd5,   b: 8'd10,  exp_diff: 8'd251, exp_borrow: 1'b1};
      vecs[2] = '{a: 8'd0,   b: 8'd0,   exp_diff: 8'd0,   exp_borrow: 1'b0};
      vecs[3] = '{a: 8'd255, b: 8'd255, exp_diff: 8'd0,   exp_borrow: 1'b0};
      vecs[4] = '{a: 8'd0,   b: 8'd1,   exp_diff: 8'd255, exp_borrow: 1'b1};

      rst_n = 1'b0; start8 = 1'b0; start4 = 1'b0;
      a8 = '0; b8 = '0; a4 = '0; b4 = '0;
      repeat (3) @(negedge clk);
      check("rst_busy8", busy8, 0);
      check("rst_done8", done8, 0);
      check("rst_diff8", diff8, 0);
      check("rst_borrow8", borrow8, 0);
      check("rst_busy4", busy4, 0);
      check("rst_done4", done4, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++)
         op8(vecs[i].a, vecs[i].b, vecs[i].exp_diff, vecs[i].exp_borrow);

      for (int i = 0; i < 20; i++) begin
         rx = 8'($urandom);
         ry = 8'($urandom);
         op8(rx, ry, 8'(ref_diff(rx, ry, 8)), rx < ry);
      end

      // start pulsed mid-operation with new operands: must be ignored
      @(negedge clk);
      start8 = 1'b1; a8 = 8'd100; b8 = 8'd37;
      @(negedge clk);
      start8 = 1'b0;
      n = 0; dc = 0;
      for (int c = 1; c <= 20; c++) begin
         if (done8) begin
            n++; dc = c; dd[0] = diff8; db[0] = borrow8;
         end
         if (c == 3) begin start8 = 1'b1; a8 = 8'd1; b8 = 8'd1; end
         if (c == 4) begin start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); end
         @(negedge clk);
      end
      $display("op w8 a=100 b=37 with ignored start -> done_count=%0d at cycle %0d diff=%0d", n, dc, dd[0]);
      check("ignored_start_done_count", n, 1);
      check("ignored_start_latency", dc, 9);
      check("ignored_start_diff", dd[0], 63);
      check("ignored_start_borrow", db[0], 0);

      // reset in the middle of an operation
      @(negedge clk);
      start8 = 1'b1; a8 = 8'd50; b8 = 8'd20;
      @(negedge clk);
      start8 = 1'b0;
      for (int c = 1; c < 4; c++) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_busy", busy8, 0);
      check("midrst_done", done8, 0);
      check("midrst_diff", diff8, 0);
      check("midrst_borrow", borrow8, 0);
      rst_n = 1'b1;
      n = 0;
      for (int c = 0; c < 15; c++) begin
         if (done8) n++;
         @(negedge clk);
      end
      $display("op w8 a=50 b=20 aborted by reset -> done_count=%0d", n);
      check("midrst_no_done", n, 0);
      op8(8'd20, 8'd50, 8'd226, 1'b1);

      // start held high: second operation accepted in the DONE cycle
      @(negedge clk);
      start8 = 1'b1; a8 = 8'd9; b8 = 8'd3;
      @(negedge clk);
      a8 = 8'd3; b8 = 8'd9;
      n = 0;
      for (int c = 1; c <= 30; c++) begin
         if (done8 && n < 4) begin
            dcyc[n] = c; dd[n] = diff8; db[n] = borrow8; n++;
         end
         if (c == 10) begin
            check("held_start_busy_after_done", busy8, 1);
            start8 = 1'b0;
         end
         @(negedge clk);
      end
      $display("held start: done_count=%0d", n);
      check("held_done_count", n, 2);
      if (n >= 2) begin
         check("held_first_latency", dcyc[0], 9);
         check("held_first_diff", dd[0], 6);
         check("held_first_borrow", db[0], 0);
         check("held_gap", dcyc[1] - dcyc[0], 9);
         check("held_second_diff", dd[1], 250);
         check("held_second_borrow", db[1], 1);
      end

      // exhaustive WIDTH=4 sweep with random idle gaps
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            op4(4'(x), 4'(y));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
